// File: rtl/sram_block_writer.sv
// rtl/sram_block_writer.sv - serialises ciphertext blocks into byte writes on an SRAM port
// Purpose: accepts one BLOCK_BYTES*8-bit block per blk_valid/blk_ready handshake.
//   Each block is written MSB byte first as BLOCK_BYTES consecutive SRAM writes at an
//   auto-incrementing write pointer, and then a one-cycle done pulse follows.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   blk_data/blk_valid/blk_ready  block input handshake
//   base_addr/addr_load           write pointer load (IDLE only)
//   w_en/r_en/addr/sram_output    SRAM write/read port
//   sram_input                    SRAM read data (one cycle after r_en)
//   done/verify_err/blk_count     completion pulse, readback result, block counter
// Optional feature: define READBACK_VERIFY_EN to read back and compare each block
//   after writing it. Without it, r_en and verify_err are tied low.
module sram_block_writer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_BYTES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BLOCK_BYTES*8-1:0] blk_data,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     addr_load,
  output logic                     w_en,
  output logic                     r_en,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [7:0]               sram_output,
  input  logic [7:0]               sram_input,
  output logic                     done,
  output logic                     verify_err,
  output logic [15:0]              blk_count
);
  localparam int DW = BLOCK_BYTES * 8;
  localparam int IW = $clog2(BLOCK_BYTES) + 1;

`ifdef READBACK_VERIFY_EN
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         blk_q, blk_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            dout_q, dout_d;
  logic [ADDR_WIDTH-1:0] start;
`ifdef READBACK_VERIFY_EN
  logic                  r_en_q, r_en_d;
  logic                  err_q, err_d;
`else
  logic                  unused_sram_input;
  assign unused_sram_input = ^sram_input;
`endif

  // Byte i of the block, byte 0 being the most significant.
  function automatic logic [7:0] byte_at(input logic [DW-1:0] blk, input logic [IW-1:0] i);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (i == IW'(k)) b = blk[(BLOCK_BYTES-1-k)*8 +: 8];
    end
    return b;
  endfunction

  assign blk_ready   = (state_q == IDLE) && !rst;
  assign done        = (state_q == DONE);
  assign w_en        = w_en_q;
  assign addr        = addr_q;
  assign sram_output = dout_q;
  assign blk_count   = cnt_q;
`ifdef READBACK_VERIFY_EN
  assign r_en        = r_en_q;
  assign verify_err  = done && err_q;
`else
  assign r_en        = 1'b0;
  assign verify_err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    w_en_d  = w_en_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
`ifdef READBACK_VERIFY_EN
    r_en_d  = r_en_q;
    err_d   = err_q;
`endif
    // A load in the same cycle as the handshake takes effect for that block.
    start   = addr_load ? base_addr : ptr_q;
    case (state_q)
      IDLE: begin
        if (addr_load) ptr_d = base_addr;
        if (blk_valid && blk_ready) begin
          // Byte 0 is issued on the accepting edge so the write port is registered.
          blk_d   = blk_data;
          idx_d   = IW'(1);
          w_en_d  = 1'b1;
          addr_d  = start;
          dout_d  = blk_data[DW-1 -: 8];
          ptr_d   = start + ADDR_WIDTH'(1);
          state_d = WRITE;
`ifdef READBACK_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (idx_q < IW'(BLOCK_BYTES)) begin
          w_en_d = 1'b1;
          addr_d = ptr_q;
          dout_d = byte_at(blk_q, idx_q);
          ptr_d  = ptr_q + ADDR_WIDTH'(1);
          idx_d  = idx_q + IW'(1);
        end else begin
          w_en_d = 1'b0;
`ifdef READBACK_VERIFY_EN
          // Pointer already sits one past the block, so the block start is ptr - BLOCK_BYTES.
          r_en_d  = 1'b1;
          addr_d  = ptr_q - ADDR_WIDTH'(BLOCK_BYTES);
          idx_d   = '0;
          state_d = VERIFY;
`else
          cnt_d   = cnt_q + 16'd1;
          state_d = DONE;
`endif
        end
      end
`ifdef READBACK_VERIFY_EN
      VERIFY: begin
        // idx_q counts verify cycles; read data for byte idx_q-1 arrives now.
        if (idx_q != '0 && sram_input != byte_at(blk_q, idx_q - IW'(1))) err_d = 1'b1;
        if (idx_q < IW'(BLOCK_BYTES - 1)) begin
          r_en_d = 1'b1;
          addr_d = ptr_q - ADDR_WIDTH'(BLOCK_BYTES) + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);
        end else begin
          r_en_d = 1'b0;
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(BLOCK_BYTES)) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
`ifdef READBACK_VERIFY_EN
      r_en_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      w_en_q  <= w_en_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
`ifdef READBACK_VERIFY_EN
      r_en_q  <= r_en_d;
      err_q   <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_sram_block_writer.sv
// tb/tb_sram_block_writer.sv - self-checking bench for sram_block_writer
module tb_sram_block_writer;
`ifdef READBACK_VERIFY_EN
  localparam int DONE_CYC = 18;
`else
  localparam int DONE_CYC = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] blk_data;
  logic        blk_valid;
  logic        blk_ready;
  logic [15:0] base_addr;
  logic        addr_load;
  logic        w_en;
  logic        r_en;
  logic [15:0] addr;
  logic [7:0]  sram_output;
  logic [7:0]  sram_input = 8'h00;
  logic        done;
  logic        verify_err;
  logic [15:0] blk_count;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:65535];
  logic        corrupt_en   = 1'b0;
  logic [15:0] corrupt_addr = 16'h0000;

  // Reference model state: where the next block should start and how many are stored.
  logic [15:0] m_ptr = 16'h0000;
  logic [15:0] m_cnt = 16'h0000;

  sram_block_writer dut (
    .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .base_addr(base_addr), .addr_load(addr_load), .w_en(w_en), .r_en(r_en), .addr(addr),
    .sram_output(sram_output), .sram_input(sram_input), .done(done), .verify_err(verify_err),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_en) mem[addr] <= sram_output;
    if (r_en) sram_input <= mem[addr] ^ ((corrupt_en && addr == corrupt_addr) ? 8'hFF : 8'h00);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] blk_byte(input logic [63:0] blk, input int i);
    logic [63:0] s;
    s = blk >> (8 * (7 - i));
    return s[7:0];
  endfunction

  // Called at #1 after a rising edge with the DUT idle; that cycle is cycle 0.
  // Returns at #1 after the edge starting cycle DONE_CYC+1.
  task automatic run_blk(input logic [63:0] blk, input logic ld, input logic [15:0] base,
                         input logic [15:0] exp_start, input logic [15:0] exp_cnt,
                         input logic exp_err, input int late_ld, input logic hold_next,
                         input logic [63:0] next_blk);
    logic [15:0] a;
    chk("ready_c0", blk_ready, 1'b1);
    blk_data  = blk;
    blk_valid = 1'b1;
    addr_load = ld;
    base_addr = base;
    for (int c = 1; c <= DONE_CYC; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        addr_load = 1'b0;
        if (hold_next) blk_data = next_blk;
        else blk_valid = 1'b0;
      end
      if (c == late_ld) begin
        addr_load = 1'b1;
        base_addr = 16'h8000;
      end else if (c == late_ld + 1) begin
        addr_load = 1'b0;
      end
      chk("w_en", w_en, (c <= 8));
      chk("ready_busy", blk_ready, 1'b0);
      chk("done", done, (c == DONE_CYC));
      chk("no_overlap", w_en & r_en, 1'b0);
      if (c <= 8) begin
        a = exp_start + 16'(c - 1);
        chk("wr_addr", addr, a);
        chk("wr_data", sram_output, blk_byte(blk, c - 1));
      end
`ifdef READBACK_VERIFY_EN
      chk("r_en", r_en, (c >= 9 && c <= 16));
      if (c >= 9 && c <= 16) begin
        a = exp_start + 16'(c - 9);
        chk("rd_addr", addr, a);
      end
`else
      chk("r_en", r_en, 1'b0);
`endif
      if (c == DONE_CYC) begin
        a = exp_start + 16'd7;
        chk("held_addr", addr, a);
        chk("held_data", sram_output, blk_byte(blk, 7));
        chk("blk_count", blk_count, exp_cnt);
        chk("verify_err", verify_err, exp_err);
      end
    end
    @(posedge clk); #1;
    chk("done_end", done, 1'b0);
    m_ptr = exp_start + 16'd8;
    m_cnt = exp_cnt;
  endtask

  typedef struct {
    logic [63:0] blk;
    logic        ld;
    logic [15:0] base;
    logic [15:0] exp_start;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [63:0] rb;
    logic        rl;
    logic [15:0] rbase;
    logic [15:0] st;

    vecs[0] = '{64'h1234567890abcdef, 1'b1, 16'h0010, 16'h0010, 16'd1};
    vecs[1] = '{64'h0102030405060708, 1'b1, 16'hFFFC, 16'hFFFC, 16'd2};
    vecs[2] = '{64'ha5a5a5a55a5a5a5a, 1'b0, 16'h7777, 16'h0004, 16'd3};
    vecs[3] = '{64'hdeadbeefcafef00d, 1'b0, 16'h0000, 16'h000C, 16'd4};

    rst = 1'b1; blk_data = '0; blk_valid = 1'b0; base_addr = '0; addr_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_en", w_en, 1'b0);
    chk("rst_r_en", r_en, 1'b0);
    chk("rst_addr", addr, 16'h0);
    chk("rst_dout", sram_output, 8'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_verr", verify_err, 1'b0);
    chk("rst_ready", blk_ready, 1'b0);
    chk("rst_cnt", blk_count, 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", blk_ready, 1'b1);

    for (int i = 0; i < 4; i++)
      run_blk(vecs[i].blk, vecs[i].ld, vecs[i].base, vecs[i].exp_start, vecs[i].exp_cnt,
              1'b0, 0, 1'b0, 64'h0);

    // Back-to-back with blk_valid held high: second block accepted in cycle 10.
    run_blk(64'h1111111122222222, 1'b1, 16'h0200, 16'h0200, m_cnt + 16'd1, 1'b0, 0, 1'b1,
            64'h3333333344444444);
    run_blk(64'h3333333344444444, 1'b0, 16'h0000, m_ptr, m_cnt + 16'd1, 1'b0, 0, 1'b0, 64'h0);

    // addr_load during WRITE cycle 4 is ignored; the next block continues contiguously.
    run_blk(64'h0f1e2d3c4b5a6978, 1'b0, 16'h0000, m_ptr, m_cnt + 16'd1, 1'b0, 4, 1'b0, 64'h0);
    run_blk(64'h8877665544332211, 1'b0, 16'h0000, m_ptr, m_cnt + 16'd1, 1'b0, 0, 1'b0, 64'h0);

    // Reset during byte 4 aborts the block.
    blk_data = 64'hcafebabe01234567; blk_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) blk_valid = 1'b0;
    end
    chk("pre_rst_w_en", w_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_w_en", w_en, 1'b0);
    chk("midrst_cnt", blk_count, 16'h0);
    chk("midrst_ready", blk_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("midrst_done", done, 1'b0);
      chk("midrst_w_en_hold", w_en, 1'b0);
    end
    rst = 1'b0;
    #1;
    chk("postrst_ready", blk_ready, 1'b1);
    m_ptr = 16'h0000;
    m_cnt = 16'h0000;
    run_blk(64'h0badf00d12345678, 1'b0, 16'h0000, 16'h0000, 16'd1, 1'b0, 0, 1'b0, 64'h0);

`ifdef READBACK_VERIFY_EN
    corrupt_en = 1'b1;
    corrupt_addr = 16'h0103;
    run_blk(64'hfedcba9876543210, 1'b1, 16'h0100, 16'h0100, m_cnt + 16'd1, 1'b1, 0, 1'b0, 64'h0);
    run_blk(64'h0123456789abcdef, 1'b0, 16'h0000, m_ptr, m_cnt + 16'd1, 1'b0, 0, 1'b0, 64'h0);
    corrupt_en = 1'b0;
`endif

    // Random blocks against the model: optional pointer loads, wraps included.
    for (int n = 0; n < 20; n++) begin
      rb = {$urandom, $urandom};
      rl = ($urandom_range(0, 3) == 0);
      rbase = 16'($urandom_range(0, 65535));
      if (n == 5) begin rl = 1'b1; rbase = 16'hFFFA; end
      st = rl ? rbase : m_ptr;
      run_blk(rb, rl, rbase, st, m_cnt + 16'd1, 1'b0, 0, 1'b0, 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
